shift_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 16-bit `barrel` rotator between two requesters. Each requester presents an operand and a shift amount on a valid/ready channel. The block grants one request at a time, registers the operands into the shared datapath, and returns the registered result with the requester's ID on a single valid/ready response channel. It sits between the two issuing units and the `barrel` instance, and it is the only driver of that instance's inputs.

---
 rtl/shift_pkg.sv | 10 +
 rtl/barrel.sv | 13 +
 rtl/shift_arbiter.sv | 79 +++++++
 tb/tb_shift_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared constants, FSM states and request type for shift_arbiter
package shift_pkg;
  localparam int W = 16;
  localparam int AW = 4;
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef struct packed {
    logic [W-1:0] a;
    logic [AW-1:0] c;
  } req_t;
endpackage

// File: rtl/barrel.sv
// barrel: combinational rotate-left of a by c
module barrel #(
  parameter int W = 16,
  parameter int AW = 4
) (
  input  logic [W-1:0]  a,
  input  logic [AW-1:0] c,
  output logic [W-1:0]  o
);
  logic [2*W-1:0] d;
  assign d = {a, a} << c;
  assign o = d[2*W-1:W];
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel rotator between two requesters
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int W = shift_pkg::W,
  parameter int AW = shift_pkg::AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [W-1:0]  req_a0,
  input  logic [W-1:0]  req_a1,
  input  logic [AW-1:0] req_c0,
  input  logic [AW-1:0] req_c1,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          rsp_id,
  output logic          busy,
  output logic [15:0]   op_count
);
  state_t state;
  logic last_g;
  logic [W-1:0] a_q;
  logic [AW-1:0] c_q;
  logic [W-1:0] bar_o;
  logic any_v;
  logic can_go;
  logic accept;
  logic g;
  req_t sel;
  assign any_v = |req_valid;
  // a tie goes to whoever did not win last time
  assign g = &req_valid ? ~last_g : req_valid[1];
  assign can_go = (state == IDLE) || (state == DONE && rsp_ready);
  assign accept = any_v && can_go;
  assign req_ready = accept ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign sel = g ? {req_a1, req_c1} : {req_a0, req_c0};
  assign busy = state != IDLE;
  barrel #(.W(W), .AW(AW)) u_barrel (
    .a(a_q),
    .c(c_q),
    .o(bar_o)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_g <= 1'b1;
      a_q <= '0;
      c_q <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= 1'b0;
      op_count <= '0;
    end else begin
      if (accept) begin
        a_q <= sel.a;
        c_q <= sel.c;
        last_g <= g;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
      case (state)
        IDLE: if (any_v) state <= EXEC;
        EXEC: begin
          rsp_data <= bar_o;
          rsp_id <= last_g;
          rsp_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= any_v ? EXEC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed stimulus with a response scoreboard for shift_arbiter
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [15:0] req_a0 = '0;
  logic [15:0] req_a1 = '0;
  logic [3:0] req_c0 = '0;
  logic [3:0] req_c1 = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic rsp_id;
  logic busy;
  logic [15:0] op_count;
  int total = 0;
  int bad = 0;
  logic [16:0] sb[$];
  logic [16:0] exp_r;
  logic [15:0] cnt = '0;
  int i0;
  int i1;

  shift_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a0(req_a0),
    .req_a1(req_a1),
    .req_c0(req_c0),
    .req_c1(req_c1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .rsp_id(rsp_id),
    .busy(busy),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rotl(input logic [15:0] a, input int c);
    logic [15:0] r;
    r = a;
    for (int i = 0; i < c; i++) r = {r[14:0], r[15]};
    return r;
  endfunction

  function automatic logic [15:0] opa(input int id, input int i);
    return id != 0 ? 16'(32'h0F3C + i * 32'h0101) : 16'(32'hC001 ^ (i * 32'h1111));
  endfunction

  function automatic logic [3:0] opc(input int id, input int i);
    return id != 0 ? 4'(15 - 2 * i) : 4'(3 * i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // a handshake is committed at the next rising edge; inputs only move just after edges
  always @(negedge clk) begin
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_unexpected observed id=%0d data=%0h expected no response", rsp_id, rsp_data);
      end else begin
        exp_r = sb.pop_front();
        chk("rsp", 32'({rsp_id, rsp_data}), 32'(exp_r));
        cnt++;
      end
    end
  end

  initial begin
    tick;
    tick;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_rsp_id", 32'(rsp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", 32'(op_count), 0);
    #2 rst_n = 1'b1;
    tick;
    chk("idle_busy", 32'(busy), 0);

    // tie right after reset: requester 0 wins first
    rsp_ready = 1'b1;
    req_a0 = 16'h8001; req_c0 = 4'd4;
    req_a1 = 16'h1234; req_c1 = 4'd0;
    req_valid = 2'b11;
    sb.push_back({1'b0, rotl(16'h8001, 4)});
    sb.push_back({1'b1, rotl(16'h1234, 0)});
    #1 chk("tie_ready0", 32'(req_ready), 'b01);
    tick;
    req_valid = 2'b10;
    chk("tie_busy", 32'(busy), 1);
    chk("tie_lat1", 32'(rsp_valid), 0);
    tick;
    chk("tie_lat2", 32'(rsp_valid), 1);
    chk("tie_data0", 32'(rsp_data), 'h0018);
    chk("tie_ready1", 32'(req_ready), 'b10);
    tick;
    req_valid = 2'b00;
    tick;
    chk("tie_data1", 32'(rsp_data), 'h1234);
    chk("tie_id1", 32'(rsp_id), 1);
    tick;
    chk("tie_idle", 32'(busy), 0);
    chk("tie_count", 32'(op_count), 32'(cnt));

    // single request
    req_a0 = 16'hAAAA; req_c0 = 4'd1;
    req_valid = 2'b01;
    sb.push_back({1'b0, rotl(16'hAAAA, 1)});
    #1 chk("single_ready", 32'(req_ready), 'b01);
    tick;
    req_valid = 2'b00;
    chk("single_lat1", 32'(rsp_valid), 0);
    tick;
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_data", 32'(rsp_data), 'h5555);
    chk("single_id", 32'(rsp_id), 0);
    tick;
    chk("single_count", 32'(op_count), 3);
    chk("single_idle", 32'(busy), 0);

    // backpressure with a competing request waiting
    rsp_ready = 1'b0;
    req_a1 = 16'h1234; req_c1 = 4'd8;
    req_valid = 2'b10;
    sb.push_back({1'b1, rotl(16'h1234, 8)});
    tick;
    req_valid = 2'b00;
    tick;
    req_a0 = 16'hBEEF; req_c0 = 4'd4;
    req_valid = 2'b01;
    sb.push_back({1'b0, rotl(16'hBEEF, 4)});
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_data", 32'(rsp_data), 'h3412);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_ready", 32'(req_ready), 0);
      tick;
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(req_ready), 'b01);
    tick;
    req_valid = 2'b00;
    tick;
    chk("bp_data2", 32'(rsp_data), 'hEEFB);
    chk("bp_id2", 32'(rsp_id), 0);
    tick;
    chk("bp_count", 32'(op_count), 32'(cnt));

    // C = 15 boundary through requester 1
    req_a1 = 16'h0001; req_c1 = 4'd15;
    req_valid = 2'b10;
    sb.push_back({1'b1, rotl(16'h0001, 15)});
    tick;
    req_valid = 2'b00;
    tick;
    chk("c15_data", 32'(rsp_data), 'h8000);
    tick;

    // fairness: both valid for eight operations
    for (int k = 0; k < 8; k++) sb.push_back({1'(k % 2), rotl(opa(k % 2, k / 2), int'(opc(k % 2, k / 2)))});
    i0 = 0;
    i1 = 0;
    req_a0 = opa(0, 0); req_c0 = opc(0, 0);
    req_a1 = opa(1, 0); req_c1 = opc(1, 0);
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1 chk("fair_ready", 32'(req_ready), (k % 2 != 0) ? 'b10 : 'b01);
      tick;
      if (k % 2 == 0) begin
        i0++;
        if (i0 < 4) begin
          req_a0 = opa(0, i0); req_c0 = opc(0, i0);
        end else req_valid[0] = 1'b0;
      end else begin
        i1++;
        if (i1 < 4) begin
          req_a1 = opa(1, i1); req_c1 = opc(1, i1);
        end else req_valid[1] = 1'b0;
      end
      tick;
    end
    tick;
    chk("fair_idle", 32'(busy), 0);
    chk("fair_count", 32'(op_count), 14);

    // reset during EXEC discards the operation
    req_a0 = 16'hFFFF; req_c0 = 4'd3;
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    chk("mid_busy_pre", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_op_count", 32'(op_count), 0);
    chk("mid_rsp_data", 32'(rsp_data), 0);
    chk("mid_rsp_id", 32'(rsp_id), 0);
    chk("mid_req_ready", 32'(req_ready), 0);
    cnt = '0;
    tick;
    tick;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("mid_quiet", 32'(rsp_valid), 0);
    end
    chk("mid_count_after", 32'(op_count), 0);

    // op_count wrap, with C = 0 passing A through
    force dut.op_count = 16'hFFFF;
    #1 release dut.op_count;
    cnt = 16'hFFFF;
    req_a0 = 16'h00F1; req_c0 = 4'd0;
    req_valid = 2'b01;
    sb.push_back({1'b0, rotl(16'h00F1, 0)});
    tick;
    req_valid = 2'b00;
    tick;
    chk("c0_data", 32'(rsp_data), 'h00F1);
    tick;
    chk("wrap_count", 32'(op_count), 0);
    chk("wrap_model", 32'(op_count), 32'(cnt));

    tick;
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
